serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 5 +
 rtl/fullSubtractor.sv | 17 +
 rtl/serial_subtractor.sv | 69 ++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encodings and default width for the serial subtractor
package serial_sub_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fullSubtractor.sv
// fullSubtractor: one-bit gate-level full subtractor (d = x - y - bin)
module fullSubtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic t, nx, nt, a1, a2;
  xor g0 (t, x, y);
  xor g1 (d, t, bin);
  not g2 (nx, x);
  not g3 (nt, t);
  and g4 (a1, nx, y);
  and g5 (a2, nt, bin);
  or  g6 (bout, a1, a2);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned x - y, LSB first, one bit per cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [WIDTH-1:0] a, b, r;
  logic br, d, bn, last;
  logic [CW-1:0] cnt;
  fullSubtractor u_fs (.x(a[0]), .y(b[0]), .bin(br), .d(d), .bout(bn));
  assign last = cnt == CW'(WIDTH - 1);
  // diff/bout are loaded only on the final shift, so they stay stable elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a     <= x;
          b     <= y;
          br    <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          a   <= a >> 1;
          b   <= b >> 1;
          r   <= {d, r[WIDTH-1:1]};
          br  <= bn;
          cnt <= cnt + 1'b1;
          if (last) begin
            diff  <= {d, r[WIDTH-1:1]};
            bout  <= bn;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for 8-bit and 4-bit serial subtractors
module tb_serial_subtractor;
  logic clk = 0, rst = 1, start8 = 0, start4 = 0;
  logic [7:0] x8 = 0, y8 = 0, diff8;
  logic [3:0] x4 = 0, y4 = 0, diff4;
  logic bout8, busy8, done8, bout4, busy4, done4;
  int vectors = 0, miscompares = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;

  task automatic launch8(input logic [7:0] xv, input logic [7:0] yv, output int lat);
    x8 = xv; y8 = yv; start8 = 1;
    q8.push_back({xv < yv, 8'(xv - yv)});
    @(negedge clk); start8 = 0; lat = 1;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    logic [8:0] e;
    int n;
    rst = 1; start8 = 1; x8 = 8'h55; y8 = 8'h11;
    repeat (2) @(negedge clk);
    vectors++;
    if ({diff8, bout8, busy8, done8} !== 11'b0) begin
      miscompares++; $display("FAIL reset_outputs got=%h want=0", {diff8, bout8, busy8, done8});
    end
    rst = 0; q8.push_back({1'b0, 8'h44});
    @(negedge clk); start8 = 0; n = 1;
    vectors++;
    if (busy8 !== 1'b1) begin miscompares++; $display("FAIL reset_release_accept busy=%b want=1", busy8); end
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    e = q8.pop_front();
    vectors++;
    if (!done8 || {bout8, diff8} !== e || n != 9) begin
      miscompares++; $display("FAIL reset_release_result got=%h lat=%0d want=%h lat=9", {bout8, diff8}, n, e);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] xs[4] = '{8'd5, 8'd3, 8'h00, 8'hA5};
    logic [7:0] ys[4] = '{8'd3, 8'd5, 8'h01, 8'hA5};
    logic [8:0] e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch8(xs[i], ys[i], lat);
      e = q8.pop_front();
      vectors++;
      if (!done8 || lat != 9) begin
        miscompares++; $display("FAIL basic_latency[%0d] got=%0d done=%b want=9", i, lat, done8);
      end
      vectors++;
      if ({bout8, diff8} !== e || busy8 !== 1'b0) begin
        miscompares++; $display("FAIL basic_result[%0d] got=%h busy=%b want=%h busy=0", i, {bout8, diff8}, busy8, e);
      end
      @(negedge clk);
    end
    x8 = 8'h3C; y8 = 8'h99;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bout8, diff8, done8, busy8} !== {e, 2'b00}) begin
      miscompares++; $display("FAIL idle_hold got=%h want=%h", {bout8, diff8, done8, busy8}, {e, 2'b00});
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] e;
    int n;
    logic glitch;
    x8 = 8'h10; y8 = 8'h01; start8 = 1;
    repeat (3) q8.push_back({1'b0, 8'h0F});
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    e = q8.pop_front();
    vectors++;
    if (!done8 || {bout8, diff8} !== e) begin
      miscompares++; $display("FAIL b2b_first got=%h done=%b want=%h", {bout8, diff8}, done8, e);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0; glitch = 0;
      do begin
        @(negedge clk); n++;
        if ((n >= 2 && n <= 9) != busy8) glitch = 1;
      end while (!done8 && n < 40);
      e = q8.pop_front();
      vectors++;
      if (n != 10 || glitch) begin
        miscompares++; $display("FAIL b2b_period[%0d] got=%0d glitch=%b want=10 glitch=0", k, n, glitch);
      end
      vectors++;
      if ({bout8, diff8} !== e) begin
        miscompares++; $display("FAIL b2b_result[%0d] got=%h want=%h", k, {bout8, diff8}, e);
      end
    end
    start8 = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy8 !== 1'b0) begin miscompares++; $display("FAIL b2b_stop busy=%b want=0", busy8); end
  endtask

  task automatic test_ignore_start;
    logic [8:0] e;
    int n;
    x8 = 8'h37; y8 = 8'h12; start8 = 1;
    q8.push_back({1'b0, 8'h25});
    @(negedge clk); start8 = 0;
    repeat (2) @(negedge clk);
    start8 = 1; x8 = 8'hFF; y8 = 8'h00;
    repeat (2) @(negedge clk);
    start8 = 0; n = 5;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    e = q8.pop_front();
    vectors++;
    if (!done8 || {bout8, diff8} !== e || n != 9) begin
      miscompares++; $display("FAIL ignore_start got=%h lat=%0d want=%h lat=9", {bout8, diff8}, n, e);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      miscompares++; $display("FAIL ignore_not_queued busy=%b done=%b want=0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_abort;
    logic [8:0] e;
    logic seen;
    int lat;
    x8 = 8'h80; y8 = 8'h01; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    vectors++;
    if ({diff8, bout8, busy8, done8} !== 11'b0) begin
      miscompares++; $display("FAIL abort_outputs got=%h want=0", {diff8, bout8, busy8, done8});
    end
    seen = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) seen = 1; end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_no_done got=1 want=0"); end
    launch8(8'h80, 8'h01, lat);
    e = q8.pop_front();
    vectors++;
    if (!done8 || {bout8, diff8} !== e || lat != 9) begin
      miscompares++; $display("FAIL abort_fresh got=%h lat=%0d want=%h lat=9", {bout8, diff8}, lat, e);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep4;
    logic [3:0] a, b;
    logic [4:0] e;
    int n;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j);
        x4 = a; y4 = b; start4 = 1;
        q4.push_back({a < b, 4'(a - b)});
        @(negedge clk); start4 = 0; n = 1;
        while (!done4 && n < 20) begin @(negedge clk); n++; end
        e = q4.pop_front();
        vectors++;
        if (!done4 || {bout4, diff4} !== e || n != 5) begin
          miscompares++;
          $display("FAIL sweep4 x=%h y=%h got=%h lat=%0d want=%h lat=5", a, b, {bout4, diff4}, n, e);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignore_start;
    test_reset_abort;
    test_sweep4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
